// File: rtl/eeprom_pkg.sv
// Shared types and constants for the parallel EEPROM bus master.
// State encoding and pin widths for the AT28C16-style 2Kx8 part.
package eeprom_pkg;

    localparam int EE_ADDR_W = 11;
    localparam int EE_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_SETUP  = 3'd1,
        S_RD_ACCESS = 3'd2,
        S_RD_DONE   = 3'd3,
        S_WR_SETUP  = 3'd4,
        S_WR_PULSE  = 3'd5,
        S_WR_HOLD   = 3'd6,
        S_WR_WAIT   = 3'd7
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eeprom_ctrl.sv
// Single-byte read/write master for an AT28C16-style parallel EEPROM.
// All pin-facing outputs are registered so the strobes are glitch-free.
module eeprom_ctrl
    import eeprom_pkg::*;
#(
    parameter int SETUP_CYC      = 1,
    parameter int READ_CYC       = 2,
    parameter int WE_PULSE_CYC   = 2,
    parameter int WRITE_WAIT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [EE_ADDR_W-1:0] req_addr,
    input  logic [EE_DATA_W-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [EE_DATA_W-1:0] resp_rdata,
    output logic                 busy,
    output logic                 ee_ce_n,
    output logic                 ee_oe_n,
    output logic                 ee_we_n,
    output logic [EE_ADDR_W-1:0] ee_addr,
    output logic [EE_DATA_W-1:0] ee_data_out,
    output logic                 ee_data_oe,
    input  logic [EE_DATA_W-1:0] ee_data_in
);

    localparam int MAX_CYC = max2(max2(SETUP_CYC, READ_CYC),
                                  max2(WE_PULSE_CYC, WRITE_WAIT_CYC));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_READ  = CNT_W'(READ_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(WE_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(WRITE_WAIT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;

    assign cnt_done = (cnt == '0);
    assign busy     = ~req_ready;

    // Counter is reloaded with (length-1) on every state entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            ee_ce_n     <= 1'b1;
            ee_oe_n     <= 1'b1;
            ee_we_n     <= 1'b1;
            ee_addr     <= '0;
            ee_data_out <= '0;
            ee_data_oe  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ee_addr     <= req_addr;
                        ee_data_out <= req_wdata;
                        req_ready   <= 1'b0;
                        ee_ce_n     <= 1'b0;
                        cnt         <= LD_SETUP;
                        if (req_we) begin
                            state      <= S_WR_SETUP;
                            ee_data_oe <= 1'b1;
                        end else begin
                            state <= S_RD_SETUP;
                        end
                    end
                end
                S_RD_SETUP: begin
                    if (cnt_done) begin
                        state   <= S_RD_ACCESS;
                        ee_oe_n <= 1'b0;
                        cnt     <= LD_READ;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RD_ACCESS: begin
                    if (cnt_done) begin
                        state      <= S_RD_DONE;
                        resp_rdata <= ee_data_in;
                        resp_valid <= 1'b1;
                        ee_ce_n    <= 1'b1;
                        ee_oe_n    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RD_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                S_WR_SETUP: begin
                    if (cnt_done) begin
                        state   <= S_WR_PULSE;
                        ee_we_n <= 1'b0;
                        cnt     <= LD_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR_PULSE: begin
                    if (cnt_done) begin
                        state   <= S_WR_HOLD;
                        ee_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // One cycle of data hold after WE rises.
                S_WR_HOLD: begin
                    state      <= S_WR_WAIT;
                    ee_ce_n    <= 1'b1;
                    ee_data_oe <= 1'b0;
                    cnt        <= LD_WAIT;
                end
                S_WR_WAIT: begin
                    if (cnt_done) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/eeprom_ctrl.md
# eeprom_ctrl

Synchronous bus master for an AT28C16-style 2K×8 parallel EEPROM. Accepts single-byte read/write requests on a valid/ready interface and sequences the active-low CE/OE/WE strobes, address and tri-state data bus with programmable cycle counts, including the post-write programming wait. Sits between the CPU control/microcode logic and the external or modelled EEPROM pins.

## Interface
- SETUP_CYC, 1: cycles address (and write data) are stable with CE low before OE or WE asserts; ≥1
- READ_CYC, 2: cycles OE is held low before read data is sampled; ≥1
- WE_PULSE_CYC, 2: WE low pulse width in cycles; ≥1
- WRITE_WAIT_CYC, 16: idle cycles after a write for internal programming (tWC); ≥1
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request accepted on valid&&ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  11  byte address
- req_wdata  in  8  write data
- resp_valid  out  1  one-cycle pulse, resp_rdata valid
- resp_rdata  out  8  read data
- busy  out  1  ~req_ready
- ee_ce_n  out  1  chip enable, active-low
- ee_oe_n  out  1  output enable, active-low
- ee_we_n  out  1  write enable, active-low
- ee_addr  out  11  address pins
- ee_data_out  out  8  data driven to EEPROM
- ee_data_oe  out  1  1 = controller drives data bus
- ee_data_in  in  8  data from EEPROM

## Operation
- States: IDLE, RD_SETUP, RD_ACCESS, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT.
- IDLE: req_ready=1, all strobes high, ee_data_oe=0. On valid&&ready register addr/wdata/we; go RD_SETUP or WR_SETUP.
- RD_SETUP (SETUP_CYC): ce_n=0, oe_n=1 → RD_ACCESS.
- RD_ACCESS (READ_CYC): ce_n=0, oe_n=0; ee_data_in captured into resp_rdata on the last cycle's edge → RD_DONE.
- RD_DONE (1 cycle): strobes high, resp_valid=1 → IDLE.
- WR_SETUP (SETUP_CYC): ce_n=0, we_n=1, ee_data_oe=1 → WR_PULSE.
- WR_PULSE (WE_PULSE_CYC): we_n=0, ce_n=0, ee_data_oe=1 → WR_HOLD.
- WR_HOLD (1 cycle): we_n=1, ce_n=0, ee_data_oe=1 (data hold) → WR_WAIT.
- WR_WAIT (WRITE_WAIT_CYC): strobes high, ee_data_oe=0 → IDLE.
- Invariants: oe_n and we_n never both low; oe_n=0 never while ee_data_oe=1; ee_addr/ee_data_out constant from accept until return to IDLE; all strobe outputs registered (glitch-free).
- Requests presented while busy are ignored (req_ready=0), not queued.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, ce_n/oe_n/we_n=1, ee_data_oe=0, ee_addr=0, ee_data_out=0, resp_valid=0, resp_rdata=0, req_ready=1.
- Reset mid-operation aborts immediately, no response; an aborted write may leave the location undefined.
- Accept edge = cycle 0. Read: resp_valid in cycle 1+SETUP_CYC+READ_CYC (defaults: 4); req_ready back in cycle 5.
- Write: we_n low cycles 2–3, req_ready back in cycle 1+SETUP_CYC+WE_PULSE_CYC+1+WRITE_WAIT_CYC (defaults: 21).
- Back-to-back: a request held valid is accepted in the first IDLE cycle; no extra bubble.
- Cycle counter width = $clog2 of the largest parameter + 1; counter reloads on every state entry.

## Structure
- eeprom_pkg: state encoding constants, EE_ADDR_W=11, EE_DATA_W=8.
- Single module; no sub-module. Top level (or bench) merges ee_data_out/ee_data_oe/ee_data_in into the inout bus.

## Test plan
- Reset: assert rst_n=0 mid-WR_PULSE -> next cycle we_n=1, ce_n=1, ee_data_oe=0, req_ready=1, resp_valid never pulses.
- Write 0x5A to 0x123, then read 0x123 against an AT28C16 behavioural model -> resp_valid in cycle 4 of the read, resp_rdata=0x5A.
- Write timing: defaults -> we_n low exactly 2 cycles, ee_data_oe high cycles 1–4, req_ready=1 at cycle 21.
- Boundary addresses: write/read 0x000=0x01 and 0x7FF=0xFE -> both read back correctly, no aliasing.
- Back-to-back reads 0x010, 0x011 with req_valid held -> second accepted in cycle 5, responses in order.
- Assertions throughout all tests: never (oe_n==0 && we_n==0), never (oe_n==0 && ee_data_oe==1), ee_addr stable while busy.
